activation_pingpong_buffer: RTL and testbench
=============================================

# activation_pingpong_buffer

- Double-buffered, multi-channel successor to the single-layer activation store.
- Each channel holds one layer output pass (channel 0 = positive pass, channel 1 = negative pass by default). Each channel has a write bank and a read bank.
- relu_norm fills the write bank while the next-layer MAC and plasticity engine read the previous pass from the read bank. When the fill completes, the banks swap under handshake.
- Sits between relu_norm and the consumers of one layer.

## Interface
- NUM_NEURONS, 256, activations per layer pass; AW = $clog2(NUM_NEURONS)
- DATA_WIDTH, 32, activation width, unsigned (post-ReLU)
- NUM_CHANNELS, 2, independent pass channels; CW = max(1,$clog2(NUM_CHANNELS))
- NUM_RD_PORTS, 2, combinational read ports
- GW (localparam), 2*DATA_WIDTH+AW, goodness width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  high when the write bank of the channel selected by wr_ch can accept a write
- wr_ch  in  CW  target channel
- wr_addr  in  AW  neuron index
- wr_data  in  DATA_WIDTH  activation
- clear  in  1  aborts the fill in progress on all channels
- rd_ch  in  NUM_RD_PORTS*CW  per-port channel select
- rd_addr  in  NUM_RD_PORTS*AW  per-port neuron index
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  per-port data, zero latency
- rd_valid  out  NUM_CHANNELS  read bank of the channel holds a complete pass
- rd_release  in  NUM_CHANNELS  consumer finished with that read bank
- wr_err  out  1  sticky: a write arrived with wr_addr >= NUM_NEURONS
- goodness  out  NUM_CHANNELS*GW  sum of squares of the current read bank

## Operation
- **Storage:** 2*NUM_CHANNELS*NUM_NEURONS words. Per-channel bank_sel selects the write bank; the read bank is its complement.
- **Write acceptance:** a write is accepted when wr_valid && wr_ready.
- **wr_ready:** equals (state[wr_ch]==FILL) && !clear, computed combinationally.
- **Out-of-range address:** the write is dropped, not counted, and sets wr_err.
- **Per-channel FSM, FILL:**
  - Every accepted write increments count[ch].
  - The accepted write that brings count to NUM_NEURONS moves the channel to FULL.
  - The producer must write each address once per pass. Duplicate addresses are still counted.
- **Per-channel FSM, FULL:** swap when !rd_valid[ch] || rd_release[ch]. On swap:
  - bank_sel toggles;
  - rd_valid[ch] is set to 1;
  - count is set to 0;
  - the FSM returns to FILL.
- **Release:** rd_release while rd_valid with no swap that cycle clears rd_valid. rd_release while !rd_valid is ignored.
- **clear:**
  - Every channel returns to FILL and count goes to 0.
  - A write presented in the same cycle is dropped.
  - Read banks, rd_valid and goodness are untouched.
  - clear and swap in the same cycle: clear wins, so no swap occurs.
- **Reads:** rd_data[p] = read bank of channel rd_ch[p] at rd_addr[p]. An out-of-range rd_ch or rd_addr returns 0.
- **Reset:**
  - All memory is zeroed.
  - bank_sel = 0, count = 0, every FSM = FILL.
  - rd_valid = 0, wr_err = 0, goodness = 0.
  - wr_ready = 1 (unless clear is asserted).
  - rd_data = 0.
  - A reset asserted mid-fill discards the partial pass.

## Timing
- Write: data is in the write bank after the accepting edge. It is not visible on rd_data until a swap.
- Last write accepted at edge E0: wr_ready for that channel is 0 from E0. Swap happens at E0+1 if the read bank is free, and rd_valid/rd_data reflect the new pass after E0+1.
- Release and FULL in the same cycle: the swap happens at that edge, rd_valid stays 1 and there is no bubble.
- Reads are combinational.
- A channel's read bank never changes while rd_valid=1 without a release.

## Configuration
- **ACT_BUF_GOODNESS_EN defined:**
  - A per-channel accumulator adds wr_data*wr_data (full GW precision, no saturation) on each accepted write.
  - On swap, goodness[ch] is loaded with the accumulator, including the final write's square, and the accumulator is zeroed.
  - clear or rst zeroes the accumulators.
- **ACT_BUF_GOODNESS_EN undefined:** the accumulators are absent and goodness is driven constant 0.

## Test plan
- **Single fill and swap.** After rst, fill ch0 addr i with data i+1 for all 256 addresses. Expect:
  - rd_valid[0]=1 two edges after the last write;
  - rd_data at addr 5 = 6;
  - goodness[0] = sum of (i+1)^2 for i=0..255 = 5,625,216 (macro on).
- **Back-pressure.** Fill ch0 twice without release. Expect:
  - wr_ready=0 for wr_ch=0 after the second fill;
  - the first pass is still readable;
  - rd_release[0] triggers a same-cycle swap with rd_valid staying 1, and the second pass is readable.
- **Dual channel, dual port.** Fill ch0 with 0xA5 and ch1 with 0x5A, interleaved. Port0 reads ch0 addr 3 = 0xA5 and port1 reads ch1 addr 3 = 0x5A in the same cycle.
- **clear mid-fill.** Clear after 100 writes to ch1. Expect:
  - count restarts from 0;
  - a write concurrent with clear is dropped;
  - 256 further writes are needed before rd_valid[1] rises;
  - goodness reflects only the post-clear writes.
- **Error and invalid write.** A write to addr >= NUM_NEURONS (with NUM_NEURONS=200) sets wr_err, leaves count unchanged, and wr_err stays 1 until rst.
- **Reset mid-operation.** Assert rst with rd_valid[0]=1 and ch1 half full. Next cycle:
  - all rd_valid=0, goodness=0, rd_data=0;
  - wr_ready=1.

Source files
------------

// File: rtl/activation_pingpong_buffer_if.sv
// Bundle of write, read, control and status signals between relu_norm, the
// layer consumers and activation_pingpong_buffer.
interface activation_pingpong_buffer_if #(
   parameter int NUM_NEURONS  = 256,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int NUM_RD_PORTS = 2
);
   localparam int AW = $clog2(NUM_NEURONS);
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int GW = 2*DATA_WIDTH + AW;

   logic                               wr_valid;
   logic                               wr_ready;
   logic [CW-1:0]                      wr_ch;
   logic [AW-1:0]                      wr_addr;
   logic [DATA_WIDTH-1:0]              wr_data;
   logic                               clear;
   logic [NUM_RD_PORTS*CW-1:0]         rd_ch;
   logic [NUM_RD_PORTS*AW-1:0]         rd_addr;
   logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data;
   logic [NUM_CHANNELS-1:0]            rd_valid;
   logic [NUM_CHANNELS-1:0]            rd_release;
   logic                               wr_err;
   logic [NUM_CHANNELS*GW-1:0]         goodness;
   logic [NUM_CHANNELS-1:0]            state_dbg;

   modport master (
      output wr_valid, wr_ch, wr_addr, wr_data, clear, rd_ch, rd_addr, rd_release,
      input  wr_ready, rd_data, rd_valid, wr_err, goodness, state_dbg
   );

   modport slave (
      input  wr_valid, wr_ch, wr_addr, wr_data, clear, rd_ch, rd_addr, rd_release,
      output wr_ready, rd_data, rd_valid, wr_err, goodness, state_dbg
   );
endinterface

// File: rtl/activation_pingpong_buffer.sv
// Double-buffered multi-channel activation store with per-channel FILL/FULL swap.
// Define ACT_BUF_GOODNESS_EN to accumulate per-pass sum of squares into goodness.
module activation_pingpong_buffer #(
   parameter int NUM_NEURONS  = 256,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int NUM_RD_PORTS = 2
) (
   input logic                         clk,
   input logic                         rst,
   activation_pingpong_buffer_if.slave bus
);
   localparam int AW = $clog2(NUM_NEURONS);
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int GW = 2*DATA_WIDTH + AW;
   localparam int NW = AW + 1;
   localparam int NB = 2*NUM_CHANNELS;

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   state_t [NUM_CHANNELS-1:0]          state;
   logic [NUM_CHANNELS-1:0][NW-1:0]    count;
   logic [NUM_CHANNELS-1:0]            bank_sel;
   logic [NUM_CHANNELS-1:0]            rd_valid_q;
   logic                               wr_err_q;
   logic [DATA_WIDTH-1:0]              mem [NB*NUM_NEURONS];

   logic          wr_ch_ok;
   logic          addr_ok;
   logic          accept;
   logic [CW-1:0] wr_idx;
   int            wr_word;

   // Handshake: a write transfers on a rising edge where wr_valid && wr_ready;
   // wr_ready is purely combinational from the selected channel's state and clear.
   assign wr_ch_ok     = int'(bus.wr_ch) < NUM_CHANNELS;
   assign wr_idx       = wr_ch_ok ? bus.wr_ch : '0;
   assign addr_ok      = int'(bus.wr_addr) < NUM_NEURONS;
   assign bus.wr_ready = wr_ch_ok && (state[wr_idx] == FILL) && !bus.clear;
   assign accept       = bus.wr_valid && bus.wr_ready;
   assign wr_word      = (2*int'(wr_idx) + int'(bank_sel[wr_idx])) * NUM_NEURONS
                         + int'(bus.wr_addr);

`ifdef ACT_BUF_GOODNESS_EN
   logic [NUM_CHANNELS-1:0][GW-1:0] acc;
   logic [NUM_CHANNELS-1:0][GW-1:0] good_q;
   logic [GW-1:0]                   sq;

   assign sq           = GW'(bus.wr_data) * GW'(bus.wr_data);
   assign bus.goodness = good_q;
`else
   assign bus.goodness = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         mem        <= '{default: '0};
         state      <= {NUM_CHANNELS{FILL}};
         count      <= '0;
         bank_sel   <= '0;
         rd_valid_q <= '0;
         wr_err_q   <= 1'b0;
`ifdef ACT_BUF_GOODNESS_EN
         acc        <= '0;
         good_q     <= '0;
`endif
      end else begin
         if (accept && addr_ok) mem[wr_word] <= bus.wr_data;
         if (accept && !addr_ok) wr_err_q <= 1'b1;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            // A swap below overrides this, so release only drops rd_valid when no swap.
            if (bus.rd_release[c]) rd_valid_q[c] <= 1'b0;
            if (bus.clear) begin
               state[c] <= FILL;
               count[c] <= '0;
`ifdef ACT_BUF_GOODNESS_EN
               acc[c]   <= '0;
`endif
            end else if (state[c] == FULL) begin
               if (!rd_valid_q[c] || bus.rd_release[c]) begin
                  bank_sel[c]   <= ~bank_sel[c];
                  rd_valid_q[c] <= 1'b1;
                  count[c]      <= '0;
                  state[c]      <= FILL;
`ifdef ACT_BUF_GOODNESS_EN
                  good_q[c]     <= acc[c];
                  acc[c]        <= '0;
`endif
               end
            end else if (accept && addr_ok && (int'(wr_idx) == c)) begin
               count[c] <= count[c] + 1'b1;
               if (count[c] == NW'(NUM_NEURONS - 1)) state[c] <= FULL;
`ifdef ACT_BUF_GOODNESS_EN
               acc[c]   <= acc[c] + sq;
`endif
            end
         end
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.wr_err   = wr_err_q;

   always_comb begin
      bus.state_dbg = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) bus.state_dbg[c] = (state[c] == FULL);
   end

   // Each port reads the complement of its channel's write bank.
   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [CW-1:0] ch;
      logic [AW-1:0] addr;
      logic          ok;
      int            idx;

      assign ch   = bus.rd_ch[p*CW +: CW];
      assign addr = bus.rd_addr[p*AW +: AW];
      assign ok   = (int'(ch) < NUM_CHANNELS) && (int'(addr) < NUM_NEURONS);
      assign idx  = ok ? (2*int'(ch) + (bank_sel[ch] ? 0 : 1)) * NUM_NEURONS + int'(addr) : 0;
      assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = ok ? mem[idx] : '0;
   end
endmodule

// File: tb/tb_activation_pingpong_buffer.sv
// Randomized and directed bench for activation_pingpong_buffer against a pass-level model.
module tb_activation_pingpong_buffer;
   localparam int NN = 256;
   localparam int DW = 32;
   localparam int NC = 2;
   localparam int GW = 72;
`ifdef ACT_BUF_GOODNESS_EN
   localparam bit GOOD_EN = 1'b1;
`else
   localparam bit GOOD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   activation_pingpong_buffer_if #(.NUM_NEURONS(256)) bus ();
   activation_pingpong_buffer_if #(.NUM_NEURONS(200)) sbus ();

   activation_pingpong_buffer #(.NUM_NEURONS(256)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );
   activation_pingpong_buffer #(.NUM_NEURONS(200)) dut_small (
      .clk(clk), .rst(rst), .bus(sbus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q [$];

   // Pass-level model: a pending pass per channel, copied whole into the read pass on swap.
   logic [DW-1:0] m_wr [NC][NN];
   logic [DW-1:0] m_rd [NC][NN];
   int            m_cnt [NC];
   bit            m_full [NC];
   bit            m_valid [NC];
   logic [GW-1:0] m_acc [NC];
   logic [GW-1:0] m_good [NC];

   task automatic check(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      bit swap [NC];
      if (rst) begin
         for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < NN; a++) begin
               m_wr[c][a] = '0;
               m_rd[c][a] = '0;
            end
            m_cnt[c] = 0; m_full[c] = 0; m_valid[c] = 0; m_acc[c] = '0; m_good[c] = '0;
         end
         return;
      end
      for (int c = 0; c < NC; c++)
         swap[c] = m_full[c] && (!m_valid[c] || bus.rd_release[c]) && !bus.clear;
      if (bus.wr_valid && !bus.clear && !m_full[bus.wr_ch]) begin
         int c;
         int a;
         c = int'(bus.wr_ch);
         a = int'(bus.wr_addr);
         m_wr[c][a] = bus.wr_data;
         m_cnt[c]++;
         m_acc[c] += GW'(bus.wr_data) * GW'(bus.wr_data);
         if (m_cnt[c] == NN) m_full[c] = 1;
      end
      for (int c = 0; c < NC; c++) begin
         if (swap[c]) begin
            for (int a = 0; a < NN; a++) m_rd[c][a] = m_wr[c][a];
            m_valid[c] = 1; m_good[c] = m_acc[c]; m_acc[c] = '0; m_cnt[c] = 0; m_full[c] = 0;
         end else if (bus.rd_release[c]) begin
            m_valid[c] = 0;
         end
         if (bus.clear) begin
            m_cnt[c] = 0; m_acc[c] = '0; m_full[c] = 0;
         end
      end
   endtask

   task automatic check_outputs();
      int ch [2];
      int ad [2];
      for (int c = 0; c < NC; c++) begin
         check("rd_valid", bus.rd_valid[c], m_valid[c]);
         check("goodness", bus.goodness[c*GW +: GW], GOOD_EN ? m_good[c] : '0);
      end
      check("wr_err", bus.wr_err, 1'b0);
      check("wr_ready", bus.wr_ready, !bus.clear && !m_full[bus.wr_ch]);
      for (int p = 0; p < 2; p++) begin
         ch[p] = $urandom_range(0, NC-1);
         ad[p] = $urandom_range(0, NN-1);
         bus.rd_ch[p] = 1'(ch[p]);
         bus.rd_addr[p*8 +: 8] = 8'(ad[p]);
         exp_q.push_back(m_rd[ch[p]][ad[p]]);
      end
      #1;
      for (int p = 0; p < 2; p++) check("rd_data", bus.rd_data[p*DW +: DW], exp_q.pop_front());
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      bus.wr_valid = 1'b0;
      bus.clear = 1'b0;
      bus.rd_release = '0;
   endtask

   task automatic put(input int c, input int a, input logic [DW-1:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_ch = 1'(c);
      bus.wr_addr = 8'(a);
      bus.wr_data = d;
      step();
      bus.wr_valid = 1'b0;
   endtask

   task automatic read2(input int c0, input int a0, input int c1, input int a1);
      bus.rd_ch = {1'(c1), 1'(c0)};
      bus.rd_addr = {8'(a1), 8'(a0)};
      #1;
   endtask

   task automatic fill_random(input int c, output logic [GW-1:0] sum);
      logic [DW-1:0] d;
      sum = '0;
      for (int i = 0; i < NN; i++) begin
         d = $urandom;
         sum += GW'(d) * GW'(d);
         put(c, i, d);
      end
   endtask

   task automatic small_put(input int a);
      sbus.wr_valid = 1'b1;
      sbus.wr_addr = 8'(a);
      sbus.wr_data = $urandom;
      step();
      sbus.wr_valid = 1'b0;
   endtask

   initial begin
      int            nxt [NC];
      int            c;
      bit            acc_ok;
      bit            clr;
      logic [GW-1:0] s;
      logic [DW-1:0] d;

      idle();
      bus.wr_ch = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_ch = '0; bus.rd_addr = '0;
      sbus.wr_valid = 1'b0; sbus.wr_ch = '0; sbus.wr_addr = '0; sbus.wr_data = '0;
      sbus.clear = 1'b0; sbus.rd_ch = '0; sbus.rd_addr = '0; sbus.rd_release = '0;

      // reset state
      rst = 1'b1;
      step(); step();
      check("rst_valid", bus.rd_valid, 2'b00);
      check("rst_ready", bus.wr_ready, 1'b1);
      check("rst_good", bus.goodness[GW-1:0], '0);
      read2(0, 5, 1, 7);
      check("rst_rd0", bus.rd_data[DW-1:0], '0);
      check("rst_rd1", bus.rd_data[2*DW-1:DW], '0);
      rst = 1'b0;

      // single fill and swap
      for (int i = 0; i < NN-1; i++) put(0, i, 32'(i+1));
      put(0, NN-1, 32'(NN));
      check("fill_pending", bus.rd_valid[0], 1'b0);
      step();
      check("fill_valid", bus.rd_valid[0], 1'b1);
      read2(0, 5, 0, 255);
      check("fill_a5", bus.rd_data[DW-1:0], 32'd6);
      check("fill_a255", bus.rd_data[2*DW-1:DW], 32'd256);
      check("fill_good", bus.goodness[GW-1:0], GOOD_EN ? 72'd5625216 : 72'd0);

      // back-pressure: second pass waits for the release
      fill_random(0, s);
      step(); step(); step();
      bus.wr_ch = 1'b0;
      #1;
      check("bp_ready", bus.wr_ready, 1'b0);
      read2(0, 5, 0, 100);
      check("bp_old5", bus.rd_data[DW-1:0], 32'd6);
      check("bp_old100", bus.rd_data[2*DW-1:DW], 32'd101);
      bus.rd_release = 2'b01;
      step();
      idle();
      check("bp_swap_valid", bus.rd_valid[0], 1'b1);
      check("bp_new_good", bus.goodness[GW-1:0], GOOD_EN ? s : '0);
      bus.rd_release = 2'b01;
      step();
      idle();
      check("bp_release", bus.rd_valid[0], 1'b0);

      // dual channel, dual port
      for (int i = 0; i < NN; i++) begin
         put(0, i, 32'hA5);
         put(1, i, 32'h5A);
      end
      step();
      read2(0, 3, 1, 3);
      check("dual_p0", bus.rd_data[DW-1:0], 32'hA5);
      check("dual_p1", bus.rd_data[2*DW-1:DW], 32'h5A);

      // clear mid-fill on ch1
      bus.rd_release = 2'b10;
      step();
      idle();
      for (int i = 0; i < 100; i++) put(1, i, $urandom);
      bus.clear = 1'b1; bus.wr_valid = 1'b1; bus.wr_ch = 1'b1; bus.wr_addr = 8'd100;
      bus.wr_data = 32'hDEAD_BEEF;
      #1;
      check("clr_ready", bus.wr_ready, 1'b0);
      step();
      idle();
      s = '0;
      for (int i = 0; i < NN-1; i++) begin
         d = $urandom;
         s += GW'(d) * GW'(d);
         put(1, i, d);
      end
      step(); step();
      check("clr_count", bus.rd_valid[1], 1'b0);
      d = $urandom;
      s += GW'(d) * GW'(d);
      put(1, NN-1, d);
      step();
      check("clr_valid", bus.rd_valid[1], 1'b1);
      check("clr_good", bus.goodness[2*GW-1:GW], GOOD_EN ? s : '0);

      // randomized traffic against the model
      bus.clear = 1'b1;
      step();
      idle();
      nxt[0] = 0; nxt[1] = 0;
      repeat (4000) begin
         c = $urandom_range(0, NC-1);
         bus.wr_valid = ($urandom_range(0, 3) != 0);
         bus.wr_ch = 1'(c);
         bus.wr_addr = 8'(nxt[c]);
         bus.wr_data = $urandom;
         bus.rd_release = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         bus.clear = ($urandom_range(0, 199) == 0);
         acc_ok = bus.wr_valid && !bus.clear && !m_full[c];
         clr = bus.clear;
         step();
         if (clr) begin
            nxt[0] = 0; nxt[1] = 0;
         end else if (acc_ok) begin
            nxt[c] = (nxt[c] + 1) % NN;
         end
      end
      idle();

      // reset mid-operation
      bus.clear = 1'b1; bus.rd_release = 2'b11;
      step();
      idle();
      fill_random(0, s);
      step();
      check("pre_rst_valid0", bus.rd_valid[0], 1'b1);
      for (int i = 0; i < NN/2; i++) put(1, i, $urandom);
      rst = 1'b1;
      step();
      check("mid_rst_valid", bus.rd_valid, 2'b00);
      check("mid_rst_good0", bus.goodness[GW-1:0], '0);
      check("mid_rst_good1", bus.goodness[2*GW-1:GW], '0);
      bus.wr_ch = 1'b1;
      read2(0, 9, 1, 9);
      check("mid_rst_ready1", bus.wr_ready, 1'b1);
      check("mid_rst_rd0", bus.rd_data[DW-1:0], '0);
      check("mid_rst_rd1", bus.rd_data[2*DW-1:DW], '0);
      rst = 1'b0;

      // out-of-range write on the 200-entry instance
      sbus.wr_valid = 1'b1; sbus.wr_ch = 1'b0; sbus.wr_addr = 8'd250; sbus.wr_data = 32'h1234;
      #1;
      check("err_ready", sbus.wr_ready, 1'b1);
      step();
      sbus.wr_valid = 1'b0;
      check("err_set", sbus.wr_err, 1'b1);
      for (int i = 0; i < 199; i++) small_put(i);
      step(); step();
      check("err_nocount", sbus.rd_valid[0], 1'b0);
      small_put(199);
      step();
      check("err_fill", sbus.rd_valid[0], 1'b1);
      check("err_sticky", sbus.wr_err, 1'b1);
      rst = 1'b1;
      step();
      check("err_rst", sbus.wr_err, 1'b0);
      rst = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
